// File: rtl/fetch_line_buffer.sv
// Single-line instruction fetch buffer: serves 32-bit words from one buffered
// 128-bit line and refills it from slow memory on a miss via start/rdy handshake.
module fetch_line_buffer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_BYTES     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_pc,
  output logic                  cpu_ready,
  output logic                  cpu_valid,
  output logic [31:0]           cpu_instr,
  output logic                  cpu_fault,
  input  logic                  flush,
  output logic                  imem_read_start,
  output logic [ADDR_WIDTH-1:0] imem_address,
  input  logic [127:0]          imem_data,
  input  logic                  imem_read_rdy,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int OFF = $clog2(LINE_BYTES);
  localparam int TAGW = ADDR_WIDTH - OFF;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]      state;
  logic            line_valid;
  logic [TAGW-1:0] tag;
  logic [127:0]    line;
  logic [TAGW-1:0] pend_tag;
  logic [1:0]      word_sel;
  logic            flush_pending;
  logic [TW-1:0]   timer;

  logic            accept;
  logic            hit;
  logic [TAGW-1:0] pc_tag;
  logic [1:0]      pc_word;

  always_comb begin
    cpu_ready = (state == IDLE);
    accept    = cpu_req && cpu_ready;
    pc_tag    = cpu_pc[ADDR_WIDTH-1:OFF];
    pc_word   = cpu_pc[3:2];
    // A same-cycle flush turns a would-be hit into a miss.
    hit       = line_valid && (tag == pc_tag) && !flush;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      line_valid      <= 1'b0;
      tag             <= '0;
      line            <= '0;
      pend_tag        <= '0;
      word_sel        <= '0;
      flush_pending   <= 1'b0;
      timer           <= '0;
      cpu_valid       <= 1'b0;
      cpu_instr       <= '0;
      cpu_fault       <= 1'b0;
      imem_read_start <= 1'b0;
      imem_address    <= '0;
      hit_count       <= '0;
      miss_count      <= '0;
    end else begin
      cpu_valid       <= 1'b0;
      cpu_fault       <= 1'b0;
      imem_read_start <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) line_valid <= 1'b0;
          if (accept) begin
            if (cpu_pc[1:0] != 2'b00) begin
              cpu_fault <= 1'b1;
            end else if (hit) begin
              cpu_valid <= 1'b1;
              cpu_instr <= line[{pc_word, 5'b0} +: 32];
              hit_count <= hit_count + 32'd1;
            end else begin
              pend_tag        <= pc_tag;
              word_sel        <= pc_word;
              imem_read_start <= 1'b1;
              imem_address    <= {pc_tag, {OFF{1'b0}}};
              miss_count      <= miss_count + 32'd1;
              timer           <= '0;
              flush_pending   <= 1'b0;
              state           <= WAIT;
            end
          end
        end
        WAIT: begin
          timer <= timer + 1'b1;
          if (flush) flush_pending <= 1'b1;
          // rdy takes priority over a coinciding timeout.
          if (imem_read_rdy) begin
            line       <= imem_data;
            tag        <= pend_tag;
            line_valid <= !(flush_pending || flush);
            cpu_valid  <= 1'b1;
            cpu_instr  <= imem_data[{word_sel, 5'b0} +: 32];
            state      <= IDLE;
          end else if (TIMEOUT_CYCLES != 0 && timer == TMAX) begin
            cpu_fault  <= 1'b1;
            line_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Scoreboard bench for fetch_line_buffer: stimulus pushes expected responses,
// a negedge monitor pops and compares them as the DUT presents outputs.
module tb_fetch_line_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req;
  logic [31:0]  cpu_pc;
  logic         cpu_ready;
  logic         cpu_valid;
  logic [31:0]  cpu_instr;
  logic         cpu_fault;
  logic         flush;
  logic         imem_read_start;
  logic [31:0]  imem_address;
  logic [127:0] imem_data;
  logic         imem_read_rdy;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  fetch_line_buffer #(
    .ADDR_WIDTH    (32),
    .LINE_BYTES    (16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_req        (cpu_req),
    .cpu_pc         (cpu_pc),
    .cpu_ready      (cpu_ready),
    .cpu_valid      (cpu_valid),
    .cpu_instr      (cpu_instr),
    .cpu_fault      (cpu_fault),
    .flush          (flush),
    .imem_read_start(imem_read_start),
    .imem_address   (imem_address),
    .imem_data      (imem_data),
    .imem_read_rdy  (imem_read_rdy),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          fault;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] start_q[$];
  int          total = 0;
  int          passed = 0;
  int          cyc = 0;

  localparam logic [127:0] L1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] L2 = 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (cpu_valid || cpu_fault) begin
        exp_t e;
        check("valid_fault_exclusive", {31'b0, cpu_valid & cpu_fault}, 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_cpu_out: valid=%b fault=%b instr=%h, none expected",
                   cpu_valid, cpu_fault, cpu_instr);
        end else begin
          e = exp_q.pop_front();
          check("out_is_fault", {31'b0, cpu_fault}, {31'b0, e.fault});
          if (!e.fault) check("cpu_instr", cpu_instr, e.instr);
        end
      end
      if (imem_read_start) begin
        if (start_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_start: addr=%h, none expected", imem_address);
        end else begin
          check("imem_address", imem_address, start_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_valid(input logic [31:0] instr);
    exp_t e;
    e.fault = 1'b0;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  task automatic push_fault();
    exp_t e;
    e.fault = 1'b1;
    e.instr = '0;
    exp_q.push_back(e);
  endtask

  task automatic do_req(input logic [31:0] pc);
    int n = 0;
    while (!cpu_ready && n < 50) begin
      tick();
      n++;
    end
    check("ready_before_req", {31'b0, cpu_ready}, 32'd1);
    cpu_req = 1'b1;
    cpu_pc  = pc;
    tick();
    cpu_req = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    @(negedge clk);
    while (!imem_read_start && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", {31'b0, imem_read_start}, 32'd1);
  endtask

  // rdy arrives k cycles after the start cycle; call right after wait_start.
  task automatic pulse_rdy(input int k, input logic [127:0] data);
    repeat (k) @(posedge clk);
    #1;
    imem_read_rdy = 1'b1;
    imem_data     = data;
    tick();
    imem_read_rdy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s_cyc, f_cyc, n;
    reset = 1'b1; cpu_req = 1'b0; cpu_pc = '0; flush = 1'b0;
    imem_data = '0; imem_read_rdy = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_cpu_valid", {31'b0, cpu_valid}, 32'd0);
    check("rst_cpu_fault", {31'b0, cpu_fault}, 32'd0);
    check("rst_cpu_instr", cpu_instr, 32'd0);
    check("rst_start", {31'b0, imem_read_start}, 32'd0);
    check("rst_address", imem_address, 32'd0);
    check("rst_hits", hit_count, 32'd0);
    check("rst_misses", miss_count, 32'd0);
    check("rst_ready", {31'b0, cpu_ready}, 32'd1);
    tick();
    reset = 1'b0;

    // Miss then hit.
    start_q.push_back(32'h40);
    push_valid(32'h11111111);
    do_req(32'h40);
    wait_start();
    check("ready_low_in_wait", {31'b0, cpu_ready}, 32'd0);
    pulse_rdy(5, L1);
    push_valid(32'h44444444);
    do_req(32'h4C);
    repeat (2) tick();
    check("t1_hits", hit_count, 32'd1);
    check("t1_misses", miss_count, 32'd1);

    // Back-to-back hits.
    push_valid(32'h11111111);
    push_valid(32'h22222222);
    push_valid(32'h33333333);
    cpu_req = 1'b1;
    cpu_pc = 32'h40; check("b2b_ready0", {31'b0, cpu_ready}, 32'd1); tick();
    cpu_pc = 32'h44; check("b2b_ready1", {31'b0, cpu_ready}, 32'd1); tick();
    cpu_pc = 32'h48; check("b2b_ready2", {31'b0, cpu_ready}, 32'd1); tick();
    cpu_req = 1'b0;
    check("b2b_ready_after", {31'b0, cpu_ready}, 32'd1);

    // Misaligned PC.
    push_fault();
    do_req(32'h42);
    repeat (3) tick();
    check("t3_hits", hit_count, 32'd4);
    check("t3_misses", miss_count, 32'd1);

    // Flush during WAIT: data delivered but line left invalid.
    start_q.push_back(32'h80);
    push_valid(32'hAAAA0001);
    do_req(32'h80);
    wait_start();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    pulse_rdy(2, L2);
    start_q.push_back(32'h80);
    push_valid(32'hBBBB0002);
    do_req(32'h84);
    wait_start();
    pulse_rdy(3, L2);
    repeat (2) tick();
    check("t4_misses", miss_count, 32'd3);

    // Timeout after 8 WAIT cycles, late rdy ignored, line invalidated.
    start_q.push_back(32'h100);
    push_fault();
    do_req(32'h100);
    wait_start();
    s_cyc = cyc;
    n = 0;
    @(negedge clk);
    while (!cpu_fault && n < 30) begin
      @(negedge clk);
      n++;
    end
    f_cyc = cyc;
    check("timeout_latency", f_cyc - s_cyc, 32'd9);
    tick();
    imem_read_rdy = 1'b1;
    imem_data = L1;
    tick();
    imem_read_rdy = 1'b0;
    tick();
    start_q.push_back(32'h80);
    push_valid(32'hBBBB0002);
    do_req(32'h84);
    wait_start();
    pulse_rdy(2, L2);
    repeat (2) tick();
    check("t5_hits", hit_count, 32'd4);
    check("t5_misses", miss_count, 32'd5);

    // Reset during WAIT, then a stray rdy.
    start_q.push_back(32'hC0);
    do_req(32'hC0);
    wait_start();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    imem_read_rdy = 1'b1;
    imem_data = L2;
    tick();
    imem_read_rdy = 1'b0;
    repeat (3) tick();
    check("t6_instr", cpu_instr, 32'd0);
    check("t6_address", imem_address, 32'd0);
    check("t6_hits", hit_count, 32'd0);
    check("t6_misses", miss_count, 32'd0);
    check("t6_ready", {31'b0, cpu_ready}, 32'd1);

    check("exp_q_drained", exp_q.size(), 32'd0);
    check("start_q_drained", start_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
